// File: rtl/marker_pkg.sv
// marker_pkg: shared types for the colour-band marker detector.
//   code_t  - 3-bit {r,g,b} colour code from the RGB compression stage
//   CODE_*  - named colour codes
//   state_e - band-matching FSM states
package marker_pkg;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } code_t;

  localparam code_t CODE_BLACK = code_t'(3'b000);
  localparam code_t CODE_RED   = code_t'(3'b100);
  localparam code_t CODE_GREEN = code_t'(3'b010);
  localparam code_t CODE_BLUE  = code_t'(3'b001);
  localparam code_t CODE_WHITE = code_t'(3'b111);

  // Per-line marker counter ceiling (optional count feature).
  localparam logic [3:0] MARKER_CNT_MAX = 4'd15;

  typedef enum logic [1:0] {
    ST_SEEK  = 2'd0,
    ST_BAND1 = 2'd1,
    ST_BAND2 = 2'd2
  } state_e;

endpackage

// File: rtl/run_length_encoder.sv
// run_length_encoder: tracks the current run of identical colour codes on a
// line and reports each completed run for one cycle.
//   clk_in, rst_in  - clock, synchronous active-high reset
//   i_take          - accepted pixel this cycle (already gated to in-line pixels)
//   i_code          - pixel colour code
//   i_start         - pixel is column 0 (prior run is discarded, not reported)
//   i_end           - pixel is the last of the line (run closes including it)
//   i_col           - column of this pixel
//   o_done          - completed run this cycle (combinational, follows i_take)
//   o_code/o_len/o_start - completed run's code, length (sat MAX_RUN+1), start column
module run_length_encoder
  import marker_pkg::*;
#(
  parameter int COLW    = 10,
  parameter int LENW    = 7,
  parameter int MAX_RUN = 64
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            i_take,
  input  code_t           i_code,
  input  logic            i_start,
  input  logic            i_end,
  input  logic [COLW-1:0] i_col,
  output logic            o_done,
  output code_t           o_code,
  output logic [LENW-1:0] o_len,
  output logic [COLW-1:0] o_start
);

  localparam logic [LENW-1:0] LEN_SAT = LENW'(MAX_RUN + 1);

  code_t           r_code;
  logic [LENW-1:0] r_len;
  logic [COLW-1:0] r_start;

  logic            w_diff;
  logic [LENW-1:0] w_len_inc;

  assign w_diff    = (i_code != r_code);
  assign w_len_inc = (r_len == LEN_SAT) ? r_len : r_len + LENW'(1);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_code  <= CODE_BLACK;
      r_len   <= '0;
      r_start <= '0;
    end else if (i_take) begin
      if (i_start || w_diff) begin
        r_code  <= i_code;
        r_len   <= LENW'(1);
        r_start <= i_col;
      end else begin
        r_len <= w_len_inc;
      end
    end
  end

  // A line-start pixel never reports (the old run is thrown away, and a
  // start+end pixel is a one-pixel run that can never qualify). When a
  // line-end pixel also changes colour, only the older run is reported:
  // the new one is a single pixel and the line is over anyway.
  always_comb begin
    o_done  = 1'b0;
    o_code  = r_code;
    o_len   = r_len;
    o_start = r_start;
    if (i_take && !i_start) begin
      if (w_diff) begin
        o_done = 1'b1;
      end else if (i_end) begin
        o_done = 1'b1;
        o_len  = w_len_inc;
      end
    end
  end

endmodule

// File: rtl/marker_run_detect.sv
// marker_run_detect: finds a three-band colour marker (PAT0, PAT1, PAT2 runs,
// each MIN_RUN..MAX_RUN pixels long, left to right) in a scanline stream.
//   clk_in, rst_in           - clock, synchronous active-high reset
//   pixel_valid_in           - compressed_in carries a pixel
//   compressed_in            - 3-bit {r,g,b} colour code
//   line_start_in/line_end_in- first/last pixel of a line (qualified by valid)
//   marker_valid_out         - one-cycle pulse, cycle after the completing pixel
//   marker_x_out             - start column of band 0 (held until next pulse)
//   marker_width_out         - total pixels in bands 0-2 (held until next pulse)
//   marker_count_out         - only with `define MARKER_COUNT_EN: markers on
//                              the current line, saturating at 15
module marker_run_detect
  import marker_pkg::*;
#(
  parameter int         LINE_WIDTH = 640,
  parameter int         MIN_RUN    = 4,
  parameter int         MAX_RUN    = 64,
  parameter logic [2:0] PAT0       = 3'b100,
  parameter logic [2:0] PAT1       = 3'b010,
  parameter logic [2:0] PAT2       = 3'b001
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               pixel_valid_in,
  input  logic [2:0]                         compressed_in,
  input  logic                               line_start_in,
  input  logic                               line_end_in,
  output logic                               marker_valid_out,
  output logic [$clog2(LINE_WIDTH)-1:0]      marker_x_out,
  output logic [$clog2(3*MAX_RUN+1)-1:0]     marker_width_out
`ifdef MARKER_COUNT_EN
  ,
  output logic [3:0]                         marker_count_out
`endif
);

  localparam int COLW = $clog2(LINE_WIDTH);
  localparam int LENW = $clog2(MAX_RUN + 2);
  localparam int WW   = $clog2(3*MAX_RUN + 1);

  localparam logic [COLW-1:0] COL_LAST = COLW'(LINE_WIDTH - 1);

  // ---------------- line framing and column counter ----------------
  logic            r_in_line;
  logic [COLW-1:0] r_col;
  logic            w_take;
  logic [COLW-1:0] w_col;

  // Pixels outside a line (after line end, or after a mid-line reset) are
  // dropped until a line-start pixel shows up.
  assign w_take = pixel_valid_in && (line_start_in || r_in_line);
  assign w_col  = line_start_in ? '0 : r_col;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_in_line <= 1'b0;
      r_col     <= '0;
    end else if (w_take) begin
      r_in_line <= !line_end_in;
      r_col     <= (w_col == COL_LAST) ? w_col : w_col + COLW'(1);
    end
  end

  // ---------------- run tracking ----------------
  logic            w_done;
  code_t           w_run_code;
  logic [LENW-1:0] w_run_len;
  logic [COLW-1:0] w_run_start;

  run_length_encoder #(
    .COLW    (COLW),
    .LENW    (LENW),
    .MAX_RUN (MAX_RUN)
  ) u_rle (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_take  (w_take),
    .i_code  (code_t'(compressed_in)),
    .i_start (line_start_in),
    .i_end   (line_end_in),
    .i_col   (w_col),
    .o_done  (w_done),
    .o_code  (w_run_code),
    .o_len   (w_run_len),
    .o_start (w_run_start)
  );

  logic          w_qual;
  logic          w_is0, w_is1, w_is2;
  logic [WW-1:0] w_len_ext;

  assign w_qual    = w_done && (w_run_len >= LENW'(MIN_RUN)) && (w_run_len <= LENW'(MAX_RUN));
  assign w_is0     = w_qual && (w_run_code == code_t'(PAT0));
  assign w_is1     = w_qual && (w_run_code == code_t'(PAT1));
  assign w_is2     = w_qual && (w_run_code == code_t'(PAT2));
  assign w_len_ext = WW'(w_run_len);

  // ---------------- band FSM ----------------
  state_e          r_state, w_state_n;
  logic [COLW-1:0] r_x0, w_x0_n;     // start column of band 0
  logic [WW-1:0]   r_w, w_w_n;       // pixels accumulated in matched bands
  logic            w_vld_n;
  logic [COLW-1:0] w_mx_n;
  logic [WW-1:0]   w_mw_n;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state          <= ST_SEEK;
      r_x0             <= '0;
      r_w              <= '0;
      marker_valid_out <= 1'b0;
      marker_x_out     <= '0;
      marker_width_out <= '0;
    end else begin
      r_state          <= w_state_n;
      r_x0             <= w_x0_n;
      r_w              <= w_w_n;
      marker_valid_out <= w_vld_n;
      marker_x_out     <= w_mx_n;
      marker_width_out <= w_mw_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_x0_n    = r_x0;
    w_w_n     = r_w;
    w_vld_n   = 1'b0;
    w_mx_n    = marker_x_out;
    w_mw_n    = marker_width_out;
    if (w_take && line_start_in) begin
      w_state_n = ST_SEEK;
    end else if (w_done) begin
      // Any run that does not extend the current match falls through to
      // the last branch, where it may itself open a new match as band 0.
      w_state_n = ST_SEEK;
      if (r_state == ST_BAND1 && w_is1) begin
        w_state_n = ST_BAND2;
        w_w_n     = r_w + w_len_ext;
      end else if (r_state == ST_BAND2 && w_is2) begin
        w_vld_n = 1'b1;
        w_mx_n  = r_x0;
        w_mw_n  = r_w + w_len_ext;
      end else if (w_is0) begin
        w_state_n = ST_BAND1;
        w_x0_n    = w_run_start;
        w_w_n     = w_len_ext;
      end
    end
  end

`ifdef MARKER_COUNT_EN
  // ---------------- per-line marker count ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      marker_count_out <= '0;
    end else if (w_take && line_start_in) begin
      marker_count_out <= '0;
    end else if (w_vld_n && marker_count_out != MARKER_CNT_MAX) begin
      marker_count_out <= marker_count_out + 4'd1;
    end
  end
`endif

endmodule
